bin2bcd_number_module: RTL and testbench

//  Iterative shift-add-3 (double-dabble) converter from an unsigned binary count to 6 packed BCD digits.

---
 rtl/smg_pkg.sv | 15 +
 rtl/bin2bcd_number_module_if.sv | 23 ++
 rtl/bin2bcd_number_module_add3.sv | 8 +
 rtl/bin2bcd_number_module.sv | 95 +++++++++
 tb/tb_bin2bcd_number_module.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/smg_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter feeding the
// seven-segment display path.
package smg_pkg;

    localparam int          DIGITS      = 6;
    localparam logic [19:0] BCD_MAX_BIN = 20'd999999;
    localparam logic [23:0] BCD_SAT     = 24'h999999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_number_module_if.sv
// Request/result bundle between the number source (master) and the converter (slave).
// Start_Sig is a request sampled only while the converter is idle; Done_Sig is a
// one-cycle pulse marking Number_Sig/Over_Sig as freshly updated.
interface bin2bcd_number_module_if #(
    parameter int BIN_W = 20
);
    logic [BIN_W-1:0] Bin_Data;
    logic             Start_Sig;
    logic             Busy_Sig;
    logic             Done_Sig;
    logic             Over_Sig;
    logic [23:0]      Number_Sig;

    modport master (
        output Bin_Data, Start_Sig,
        input  Busy_Sig, Done_Sig, Over_Sig, Number_Sig
    );

    modport slave (
        input  Bin_Data, Start_Sig,
        output Busy_Sig, Done_Sig, Over_Sig, Number_Sig
    );
endinterface

// File: rtl/bin2bcd_number_module_add3.sv
// One BCD digit correction stage of the double-dabble shift: add 3 when the digit
// would reach 10 or more after the next doubling.
module bcd_add3_cell (
    input  logic [3:0] in_digit,
    output logic [3:0] out_digit
);
    assign out_digit = (in_digit >= 4'd5) ? in_digit + 4'd3 : in_digit;
endmodule

// File: rtl/bin2bcd_number_module.sv
// Iterative double-dabble converter: BIN_W shift cycles per conversion, result held
// in Number_Sig until the next conversion completes (saturating above 999999).
module bin2bcd_number_module
    import smg_pkg::*;
#(
    parameter int BIN_W = 20
) (
    input  logic                     CLK,
    input  logic                     RST,
    bin2bcd_number_module_if.slave   bus,
    output state_t                   dbg_state
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t           state_q, state_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [23:0]      scratch_q, scratch_d;
    logic [23:0]      scratch_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             over_q, over_d;
    logic [23:0]      number_q, number_d;
    logic             over_out_q, over_out_d;
    logic             done_q, done_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_cell u_cell (
            .in_digit  (scratch_q[4*g +: 4]),
            .out_digit (scratch_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        over_d     = over_q;
        number_d   = number_q;
        over_out_d = over_out_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start_Sig) begin
                    sr_d      = bus.Bin_Data;
                    scratch_d = '0;
                    cnt_d     = '0;
                    over_d    = 32'(bus.Bin_Data) > 32'(BCD_MAX_BIN);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Digits beyond the sixth fall off the top; only over-range inputs produce them.
                {scratch_d, sr_d} = {scratch_adj, sr_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) state_d = DONE;
            end
            DONE: begin
                number_d   = over_q ? BCD_SAT : scratch_q;
                over_out_d = over_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            over_q     <= 1'b0;
            number_q   <= '0;
            over_out_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            over_q     <= over_d;
            number_q   <= number_d;
            over_out_q <= over_out_d;
            done_q     <= done_d;
        end
    end

    assign bus.Busy_Sig   = (state_q != IDLE);
    assign bus.Done_Sig   = done_q;
    assign bus.Over_Sig   = over_out_q;
    assign bus.Number_Sig = number_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_bin2bcd_number_module.sv
// Directed bench for the binary-to-BCD converter: latency, boundaries, saturation,
// busy-time start rejection, reset abort and held-start retriggering.
module tb_bin2bcd_number_module;
    import smg_pkg::*;

    logic   CLK = 1'b0;
    logic   RST = 1'b1;
    state_t dbg_state;
    int     tests_run = 0;
    int     tests_failed = 0;

    bin2bcd_number_module_if #(.BIN_W(20)) bus ();

    bin2bcd_number_module #(.BIN_W(20)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Starts one conversion and returns the cycle count from acceptance to Done_Sig (-1 on timeout).
    task automatic run_conv(input logic [19:0] value, output int lat);
        bus.Bin_Data  = value;
        bus.Start_Sig = 1'b1;
        tick();
        bus.Start_Sig = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.Done_Sig === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.Start_Sig = 1'b0;
        bus.Bin_Data  = '0;
        tick();
        tick();
        tests_run += 5;
        if (bus.Number_Sig !== 24'h000000) begin tests_failed++; $display("FAIL reset_number got=%h exp=000000", bus.Number_Sig); end
        if (bus.Over_Sig !== 1'b0) begin tests_failed++; $display("FAIL reset_over got=%b exp=0", bus.Over_Sig); end
        if (bus.Done_Sig !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", bus.Done_Sig); end
        if (bus.Busy_Sig !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.Busy_Sig); end
        if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        bus.Bin_Data  = 20'd123456;
        bus.Start_Sig = 1'b1;
        tick();
        bus.Start_Sig = 1'b0;
        tests_run++;
        if (bus.Busy_Sig !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_after_accept got=%b exp=1", bus.Busy_Sig); end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.Done_Sig === 1'b1) begin lat = i; break; end
        end
        tests_run += 4;
        if (lat != 21) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=21", lat); end
        if (bus.Number_Sig !== 24'h123456) begin tests_failed++; $display("FAIL basic_number got=%h exp=123456", bus.Number_Sig); end
        if (bus.Over_Sig !== 1'b0) begin tests_failed++; $display("FAIL basic_over got=%b exp=0", bus.Over_Sig); end
        if (bus.Busy_Sig !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_at_done got=%b exp=0", bus.Busy_Sig); end
        tick();
        tests_run++;
        if (bus.Done_Sig !== 1'b0) begin tests_failed++; $display("FAIL basic_done_single got=%b exp=0", bus.Done_Sig); end
    endtask

    task automatic test_boundaries();
        logic [19:0] vin [5] = '{20'd0, 20'd999999, 20'd7, 20'd1000000, 20'd1048575};
        logic [23:0] vexp[5] = '{24'h000000, 24'h999999, 24'h000007, 24'h999999, 24'h999999};
        logic        oexp[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_conv(vin[i], lat);
            tests_run += 3;
            if (lat != 21) begin tests_failed++; $display("FAIL bound_latency[%0d] got=%0d exp=21", i, lat); end
            if (bus.Number_Sig !== vexp[i]) begin tests_failed++; $display("FAIL bound_number[%0d] got=%h exp=%h", i, bus.Number_Sig, vexp[i]); end
            if (bus.Over_Sig !== oexp[i]) begin tests_failed++; $display("FAIL bound_over[%0d] got=%b exp=%b", i, bus.Over_Sig, oexp[i]); end
        end
        run_conv(20'd42, lat);
        tests_run += 2;
        if (bus.Number_Sig !== 24'h000042) begin tests_failed++; $display("FAIL after_over_number got=%h exp=000042", bus.Number_Sig); end
        if (bus.Over_Sig !== 1'b0) begin tests_failed++; $display("FAIL after_over_flag got=%b exp=0", bus.Over_Sig); end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        int first = -1;
        logic [23:0] seen = '0;
        bus.Bin_Data  = 20'd500;
        bus.Start_Sig = 1'b1;
        tick();
        bus.Start_Sig = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            bus.Start_Sig = (i == 5);
            if (i == 5) bus.Bin_Data = 20'd777;
            if (i == 12) bus.Bin_Data = 20'd999;
            tick();
            if (bus.Done_Sig === 1'b1) begin
                dones++;
                if (first < 0) begin first = i; seen = bus.Number_Sig; end
            end
        end
        bus.Start_Sig = 1'b0;
        tests_run += 4;
        if (dones != 1) begin tests_failed++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
        if (first != 21) begin tests_failed++; $display("FAIL busy_latency got=%0d exp=21", first); end
        if (seen !== 24'h000500) begin tests_failed++; $display("FAIL busy_number got=%h exp=000500", seen); end
        if (bus.Number_Sig !== 24'h000500) begin tests_failed++; $display("FAIL busy_number_held got=%h exp=000500", bus.Number_Sig); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int dones = 0;
        run_conv(20'd654321, lat);
        tests_run++;
        if (bus.Number_Sig !== 24'h654321) begin tests_failed++; $display("FAIL abort_pre_number got=%h exp=654321", bus.Number_Sig); end
        bus.Bin_Data  = 20'd111111;
        bus.Start_Sig = 1'b1;
        tick();
        bus.Start_Sig = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        RST = 1'b1;
        tick();
        tests_run += 5;
        if (bus.Number_Sig !== 24'h000000) begin tests_failed++; $display("FAIL abort_number got=%h exp=000000", bus.Number_Sig); end
        if (bus.Over_Sig !== 1'b0) begin tests_failed++; $display("FAIL abort_over got=%b exp=0", bus.Over_Sig); end
        if (bus.Done_Sig !== 1'b0) begin tests_failed++; $display("FAIL abort_done got=%b exp=0", bus.Done_Sig); end
        if (bus.Busy_Sig !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", bus.Busy_Sig); end
        if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, IDLE); end
        RST = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.Done_Sig === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 0) begin tests_failed++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        run_conv(20'd250, lat);
        tests_run += 2;
        if (lat != 21) begin tests_failed++; $display("FAIL abort_recover_latency got=%0d exp=21", lat); end
        if (bus.Number_Sig !== 24'h000250) begin tests_failed++; $display("FAIL abort_recover_number got=%h exp=000250", bus.Number_Sig); end
    endtask

    task automatic test_held_start();
        int done_at[$];
        int unstable = 0;
        tick();
        bus.Bin_Data  = 20'd31;
        bus.Start_Sig = 1'b1;
        tick();
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (bus.Done_Sig === 1'b1) done_at.push_back(i);
            if (done_at.size() > 0 && bus.Number_Sig !== 24'h000031) unstable++;
        end
        bus.Start_Sig = 1'b0;
        tests_run += 2;
        if (done_at.size() != 3) begin tests_failed++; $display("FAIL held_done_count got=%0d exp=3", done_at.size()); end
        if (unstable != 0) begin tests_failed++; $display("FAIL held_number_stable got=%0d bad cycles exp=0", unstable); end
        if (done_at.size() == 3) begin
            tests_run += 3;
            if (done_at[0] != 21) begin tests_failed++; $display("FAIL held_first_done got=%0d exp=21", done_at[0]); end
            if (done_at[1] - done_at[0] != 22) begin tests_failed++; $display("FAIL held_period1 got=%0d exp=22", done_at[1] - done_at[0]); end
            if (done_at[2] - done_at[1] != 22) begin tests_failed++; $display("FAIL held_period2 got=%0d exp=22", done_at[2] - done_at[1]); end
        end
        for (int i = 0; i < 30; i++) tick();
    endtask

    initial begin
        bus.Bin_Data  = '0;
        bus.Start_Sig = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_busy_ignore();
        test_reset_abort();
        test_held_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
